// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding, operand select and load-use detection.
// Optional EX_STALL_CNT_EN adds a 32-bit count of load-use bubbles.
module ex_operand_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [4:0]    id_alu_ctrl,
  input  logic          id_sign,
  input  logic          id_alu_src1,
  input  logic          id_alu_src2,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          mem_hold,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          id_stall,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [4:0]    alu_ctrl,
  output logic          alu_sign,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]   bubble_cnt
`endif
);

  logic [RW-1:0] rs_q, rt_q;
  logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]    shamt_q;
  logic          src1_q, src2_q;
  logic          load_use;
  logic          ctl_en;
  logic [DW-1:0] fwd_rs, fwd_rt;

  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign id_stall = load_use | mem_hold;
  assign ctl_en   = id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      shamt_q       <= '0;
      alu_ctrl      <= '0;
      alu_sign      <= 1'b0;
      src1_q        <= 1'b0;
      src2_q        <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (mem_hold) begin
      // Downstream stall: every field keeps its value.
    end else if (flush || load_use) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      shamt_q       <= '0;
      alu_ctrl      <= '0;
      alu_sign      <= 1'b0;
      src1_q        <= 1'b0;
      src2_q        <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else begin
      ex_valid      <= id_valid;
      ex_rd         <= id_rd;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      imm_q         <= id_imm;
      shamt_q       <= id_shamt;
      alu_ctrl      <= id_alu_ctrl;
      alu_sign      <= id_sign;
      src1_q        <= id_alu_src1;
      src2_q        <= id_alu_src2;
      ex_reg_write  <= id_reg_write & ctl_en;
      ex_mem_read   <= id_mem_read & ctl_en;
      ex_mem_write  <= id_mem_write & ctl_en;
      ex_mem_to_reg <= id_mem_to_reg & ctl_en;
    end
  end

  // EX/MEM result is younger than MEM/WB, so it wins; $0 is never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_q)) begin
      fwd_rs = exm_data;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q)) begin
      fwd_rs = wb_data;
    end
    fwd_rt = rt_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rt_q)) begin
      fwd_rt = exm_data;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q)) begin
      fwd_rt = wb_data;
    end
  end

  assign alu_in1       = src1_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
  assign alu_in2       = src2_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;

`ifdef EX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (load_use && !mem_hold) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for forwarding/select, hand sequences
// for reset, load-use, flush/hold interaction and reset during a stall.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_alu_ctrl;
  logic        id_sign, id_alu_src1, id_alu_src2;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush, mem_hold;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        id_stall;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  alu_ctrl, ex_rd;
  logic        alu_sign, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef EX_STALL_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_ctrl(id_alu_ctrl), .id_sign(id_sign),
    .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .mem_hold(mem_hold),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_stall(id_stall), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_ctrl(alu_ctrl), .alu_sign(alu_sign), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef EX_STALL_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt;
    logic        src1, src2, rw, mw;
    logic        exm_w;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        wb_w;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] e_in1, e_in2, e_st;
    logic        e_valid, e_rw, e_mw;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alu_ctrl = 0; id_sign = 0; id_alu_src1 = 0;
    id_alu_src2 = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; flush = 0; mem_hold = 0; exm_reg_write = 0; exm_rd = 0;
    exm_data = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic load_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [4:0] ctrl, input logic mem_rd);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_alu_ctrl = ctrl;
    id_reg_write = 1; id_mem_read = mem_rd; id_mem_to_reg = mem_rd;
  endtask

  initial begin
    clear_inputs();
    // Reset with random inputs
    rst_n = 0;
    id_valid = 1; id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_alu_ctrl = 5'($urandom);
    id_reg_write = 1; id_mem_read = 1; mem_hold = 1'($urandom);
    exm_reg_write = 1; exm_rd = 5'($urandom); exm_data = $urandom;
    tick(); tick();
    check("rst_ex_valid", {31'b0, ex_valid}, 0);
    check("rst_ex_rd", {27'b0, ex_rd}, 0);
    check("rst_alu_ctrl", {27'b0, alu_ctrl}, 0);
    check("rst_ctrls", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_id_stall", {31'b0, id_stall}, {31'b0, mem_hold});
    clear_inputs();
    rst_n = 1;
    #2;

    // Forwarding and operand-select table
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    vecs[0].valid = 1; vecs[0].rs = 1; vecs[0].rt = 2; vecs[0].rs_data = 5; vecs[0].rt_data = 7;
    vecs[0].rw = 1; vecs[0].e_in1 = 5; vecs[0].e_in2 = 7; vecs[0].e_st = 7;
    vecs[0].e_valid = 1; vecs[0].e_rw = 1;
    vecs[1].valid = 1; vecs[1].rs = 3; vecs[1].rt = 4; vecs[1].rs_data = 32'h11;
    vecs[1].rt_data = 32'h22; vecs[1].rw = 1; vecs[1].exm_w = 1; vecs[1].exm_rd = 3;
    vecs[1].exm_data = 32'hAAAA_0000; vecs[1].wb_w = 1; vecs[1].wb_rd = 3;
    vecs[1].wb_data = 32'h1234; vecs[1].e_in1 = 32'hAAAA_0000; vecs[1].e_in2 = 32'h22;
    vecs[1].e_st = 32'h22; vecs[1].e_valid = 1; vecs[1].e_rw = 1;
    vecs[2] = vecs[1]; vecs[2].exm_w = 0; vecs[2].e_in1 = 32'h1234;
    vecs[3] = vecs[1]; vecs[3].rs = 0; vecs[3].rs_data = 32'h55; vecs[3].exm_rd = 0;
    vecs[3].wb_rd = 0; vecs[3].e_in1 = 32'h55;
    vecs[4].valid = 1; vecs[4].src1 = 1; vecs[4].shamt = 4; vecs[4].rs = 5;
    vecs[4].rs_data = 32'h999; vecs[4].rt = 6; vecs[4].rt_data = 1; vecs[4].rw = 1;
    vecs[4].e_in1 = 4; vecs[4].e_in2 = 1; vecs[4].e_st = 1; vecs[4].e_valid = 1;
    vecs[4].e_rw = 1;
    vecs[5].valid = 1; vecs[5].src2 = 1; vecs[5].imm = 8; vecs[5].rs = 7;
    vecs[5].rs_data = 32'h10; vecs[5].rt = 6; vecs[5].rt_data = 32'h99; vecs[5].mw = 1;
    vecs[5].exm_w = 1; vecs[5].exm_rd = 6; vecs[5].exm_data = 32'hCAFE;
    vecs[5].e_in1 = 32'h10; vecs[5].e_in2 = 8; vecs[5].e_st = 32'hCAFE;
    vecs[5].e_valid = 1; vecs[5].e_mw = 1;
    vecs[6].valid = 1; vecs[6].rs = 11; vecs[6].rs_data = 3; vecs[6].rt = 9;
    vecs[6].wb_w = 1; vecs[6].wb_rd = 9; vecs[6].wb_data = 32'h77; vecs[6].exm_w = 1;
    vecs[6].exm_rd = 10; vecs[6].exm_data = 5; vecs[6].rw = 1; vecs[6].e_in1 = 3;
    vecs[6].e_in2 = 32'h77; vecs[6].e_st = 32'h77; vecs[6].e_valid = 1; vecs[6].e_rw = 1;
    vecs[7].valid = 0; vecs[7].rw = 1; vecs[7].mw = 1; vecs[7].rs = 1;
    vecs[7].rs_data = 32'h42; vecs[7].rt = 2; vecs[7].rt_data = 32'h43;
    vecs[7].e_in1 = 32'h42; vecs[7].e_in2 = 32'h43; vecs[7].e_st = 32'h43;
    vecs[8].valid = 1; vecs[8].rs = 12; vecs[8].rt = 13; vecs[8].rs_data = 1;
    vecs[8].rt_data = 2; vecs[8].exm_w = 1; vecs[8].exm_rd = 12; vecs[8].exm_data = 32'h100;
    vecs[8].wb_w = 1; vecs[8].wb_rd = 13; vecs[8].wb_data = 32'h200; vecs[8].rw = 1;
    vecs[8].e_in1 = 32'h100; vecs[8].e_in2 = 32'h200; vecs[8].e_st = 32'h200;
    vecs[8].e_valid = 1; vecs[8].e_rw = 1;
    vecs[9].valid = 1; vecs[9].rs = 14; vecs[9].rt = 15; vecs[9].rs_data = 32'hF;
    vecs[9].rt_data = 32'hE; vecs[9].wb_rd = 14; vecs[9].wb_data = 32'hBAD;
    vecs[9].exm_rd = 15; vecs[9].exm_data = 32'hBAD; vecs[9].e_in1 = 32'hF;
    vecs[9].e_in2 = 32'hE; vecs[9].e_st = 32'hE; vecs[9].e_valid = 1;

    for (int i = 0; i < NV; i++) begin
      id_valid = vecs[i].valid; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = 5'(16 + i);
      id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data; id_imm = vecs[i].imm;
      id_shamt = vecs[i].shamt; id_alu_ctrl = 5'(i + 1); id_sign = 1'(i);
      id_alu_src1 = vecs[i].src1; id_alu_src2 = vecs[i].src2;
      id_reg_write = vecs[i].rw; id_mem_write = vecs[i].mw;
      exm_reg_write = vecs[i].exm_w; exm_rd = vecs[i].exm_rd; exm_data = vecs[i].exm_data;
      wb_reg_write = vecs[i].wb_w; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      tick();
      check($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].e_in1);
      check($sformatf("v%0d_alu_in2", i), alu_in2, vecs[i].e_in2);
      check($sformatf("v%0d_store", i), ex_store_data, vecs[i].e_st);
      check($sformatf("v%0d_valid_rw_mw", i), {29'b0, ex_valid, ex_reg_write, ex_mem_write},
            {29'b0, vecs[i].e_valid, vecs[i].e_rw, vecs[i].e_mw});
      if (vecs[i].valid) begin
        check($sformatf("v%0d_ctrl_rd_sign", i), {21'b0, alu_sign, alu_ctrl, ex_rd},
              {21'b0, 1'(i), 5'(i + 1), 5'(16 + i)});
      end
    end

    // Load-use: lw $8 in EX, consumer reads $8
    clear_inputs();
    load_instr(5'd1, 5'd2, 5'd8, 5'd0, 1'b1);
    tick();
    clear_inputs();
    load_instr(5'd8, 5'd3, 5'd9, 5'd5, 1'b0);
    id_rt_data = 3;
    #1;
    check("lu_id_stall", {31'b0, id_stall}, 1);
    tick();
    check("lu_bubble", {21'b0, ex_valid, ex_reg_write, ex_mem_read, alu_ctrl, ex_rd}, 0);
    check("lu_stall_clear", {31'b0, id_stall}, 0);
`ifdef EX_STALL_CNT_EN
    check("lu_bubble_cnt", bubble_cnt, 1);
`endif
    tick();
    wb_reg_write = 1; wb_rd = 8; wb_data = 32'hDEAD;
    #1;
    check("lu_fwd_in1", alu_in1, 32'hDEAD);
    check("lu_loaded", {26'b0, ex_valid, alu_ctrl}, {26'b0, 1'b1, 5'd5});

    // Load to $0 never stalls
    clear_inputs();
    load_instr(5'd1, 5'd2, 5'd0, 5'd0, 1'b1);
    tick();
    load_instr(5'd0, 5'd0, 5'd3, 5'd1, 1'b0);
    #1;
    check("lu_r0_no_stall", {31'b0, id_stall}, 0);

    // Flush vs hold
    clear_inputs();
    load_instr(5'd1, 5'd2, 5'd4, 5'd3, 1'b0);
    tick();
    load_instr(5'd5, 5'd6, 5'd7, 5'd9, 1'b0);
    flush = 1;
    tick();
    check("fl_bubble", {26'b0, ex_valid, alu_ctrl}, 0);
    flush = 0;
    load_instr(5'd1, 5'd2, 5'd4, 5'd3, 1'b0);
    tick();
    load_instr(5'd5, 5'd6, 5'd7, 5'd9, 1'b0);
    flush = 1; mem_hold = 1;
    #1;
    check("hold_id_stall", {31'b0, id_stall}, 1);
    tick();
    check("hold_keeps", {21'b0, ex_valid, alu_ctrl, ex_rd}, {21'b0, 1'b1, 5'd3, 5'd4});
    mem_hold = 0;
    tick();
    check("hold_release_flush", {26'b0, ex_valid, alu_ctrl}, 0);

    // Reset pulse while a load-use stall is active
    clear_inputs();
    load_instr(5'd1, 5'd2, 5'd8, 5'd0, 1'b1);
    tick();
    load_instr(5'd8, 5'd0, 5'd9, 5'd5, 1'b0);
    #1;
    check("rs_pre_stall", {31'b0, id_stall}, 1);
    #1 rst_n = 0;
    #1;
    check("rs_outputs", {20'b0, id_stall, ex_valid, ex_mem_read, alu_ctrl, ex_rd}, 0);
`ifdef EX_STALL_CNT_EN
    check("rs_bubble_cnt", bubble_cnt, 0);
`endif
    rst_n = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
